// File: rtl/seq_mul_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
package seq_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Widest operand the magnitude helper can handle.
  localparam int MAX_W = 256;

  // Number of BUSY iterations for a given operand width and digit size.
  function automatic int calc_iters(input int width, input int digit);
    return width / digit;
  endfunction

  // Two's-complement magnitude when neg is set, otherwise pass-through.
  // Callers keep only their low WIDTH bits. The most negative value maps to
  // itself, which is the correct unsigned magnitude.
  function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] x,
                                             input logic             neg);
    return neg ? (~x + MAX_W'(1)) : x;
  endfunction

endpackage

// File: rtl/mul_digit_pp.sv
// Combinational WIDTH x DIGIT partial-product generator. Kept as its own
// block so the inner AND/add array can be optimised in isolation.
module mul_digit_pp #(
  parameter int WIDTH = 64,
  parameter int DIGIT = 4
) (
  input  logic [WIDTH-1:0]       a,
  input  logic [DIGIT-1:0]       d,
  output logic [WIDTH+DIGIT-1:0] pp
);

  // Sum of a shifted by each set bit of the digit.
  always_comb begin
    pp = '0;
    for (int i = 0; i < DIGIT; i++) begin
      if (d[i]) pp = pp + ((WIDTH+DIGIT)'(a) << i);
    end
  end

endmodule

// File: rtl/seq_mul.sv
// Iterative signed/unsigned multiplier: DIGIT multiplier bits per cycle,
// valid/ready on both sides, one product per N+2 cycles.
module seq_mul
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DIGIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   mul
);

  localparam int N     = calc_iters(WIDTH, DIGIT);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0 ||
      WIDTH > MAX_W) begin : g_bad_params
    $error("seq_mul: WIDTH must be >= 2, <= MAX_W and a multiple of DIGIT");
  end

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic                 neg;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc, acc_nxt, pp_sh;
  logic [WIDTH+DIGIT-1:0] pp;
  logic [MAX_W-1:0]     a_abs, b_abs;
  logic                 last;

  // Operand magnitudes are taken only at the accept edge.
  assign a_abs = abs_w(MAX_W'(a), is_signed & a[WIDTH-1]);
  assign b_abs = abs_w(MAX_W'(b), is_signed & b[WIDTH-1]);

  mul_digit_pp #(.WIDTH(WIDTH), .DIGIT(DIGIT)) u_pp (
    .a  (a_mag),
    .d  (b_mag[DIGIT-1:0]),
    .pp (pp)
  );

  // Partial product lands at bit cnt*DIGIT of the double-width accumulator.
  assign pp_sh   = (2*WIDTH)'(pp) << (cnt * DIGIT);
  assign acc_nxt = acc + pp_sh;
  assign last    = (cnt == CNT_W'(N - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, shift-add iteration and final sign fixup.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_mag <= '0;
      b_mag <= '0;
      neg   <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      mul   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_mag <= a_abs[WIDTH-1:0];
            b_mag <= b_abs[WIDTH-1:0];
            neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            cnt   <= '0;
            acc   <= '0;
          end
        end
        BUSY: begin
          acc   <= acc_nxt;
          b_mag <= b_mag >> DIGIT;
          cnt   <= cnt + CNT_W'(1);
          if (last) mul <= neg ? -acc_nxt : acc_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul.sv
// Self-checking bench for seq_mul: directed cases on a 64/4 instance plus
// random regression on several WIDTH/DIGIT configurations.
module tb_seq_mul;

  logic          clk;
  logic          rst;
  logic          in_valid, in_ready, is_signed, out_valid, out_ready;
  logic [63:0]   a, b;
  logic [127:0]  mul;

  int n_checks = 0;
  int n_errors = 0;
  int gen_done = 0;
  logic [127:0] q[$];

  localparam int NUM_GEN = 5;

  seq_mul #(.WIDTH(64), .DIGIT(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid),
    .out_ready(out_ready), .mul(mul)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference product of w-bit operands, truncated to 2w bits.
  function automatic logic [127:0] ref_mul(input logic [63:0] x, input logic [63:0] y,
                                           input logic s, input int w);
    logic [127:0] m, m2, xe, ye, tx, ty;
    m  = (128'd1 << w) - 128'd1;
    xe = {64'd0, x} & m;
    ye = {64'd0, y} & m;
    tx = xe >> (w - 1);
    ty = ye >> (w - 1);
    if (s && tx[0]) xe = xe | ~m;
    if (s && ty[0]) ye = ye | ~m;
    m2 = (w >= 64) ? '1 : ((128'd1 << (2 * w)) - 128'd1);
    return (xe * ye) & m2;
  endfunction

  // One transaction on the 64/4 instance with optional output backpressure.
  task automatic main_op(input logic [63:0] op_a, input logic [63:0] op_b,
                         input logic ts, input int hold, input string tag);
    int lat;
    logic rdy_bad;
    logic [127:0] e;
    a = op_a; b = op_b; is_signed = ts; in_valid = 1'b1; out_ready = 1'b0;
    chk({tag, "_idle_rdy"}, 128'(in_ready), 128'd1);
    @(posedge clk);
    q.push_back(ref_mul(op_a, op_b, ts, 64));
    #1;
    in_valid = 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; is_signed = ~ts;
    lat = 0; rdy_bad = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 128'(lat), 128'd16);
    chk({tag, "_busy_rdy"}, 128'(rdy_bad), 128'd0);
    for (int i = 0; i < hold; i++) begin
      chk({tag, "_hold_vld"}, 128'(out_valid), 128'd1);
      chk({tag, "_hold_rdy"}, 128'(in_ready), 128'd0);
      chk({tag, "_hold_mul"}, mul, q[0]);
      @(posedge clk); #1;
    end
    e = q.pop_front();
    chk({tag, "_mul"}, mul, e);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_post_vld"}, 128'(out_valid), 128'd0);
    chk({tag, "_post_rdy"}, 128'(in_ready), 128'd1);
  endtask

  // Directed sequence and random regression on the main instance.
  initial begin
    int guard;
    logic seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; is_signed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_mul", mul, 128'd0);
    rst = 1'b0;

    main_op(64'd3, 64'd5, 1'b0, 0, "u3x5");
    chk("u3x5_ref", ref_mul(64'd3, 64'd5, 1'b0, 64), 128'd15);
    main_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd6, 1'b1, 0, "s_m7x6");
    chk("s_m7x6_ref", ref_mul(64'hFFFF_FFFF_FFFF_FFF9, 64'd6, 1'b1, 64),
        128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFD6);
    main_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd6, 1'b0, 0, "u_m7x6");
    main_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 0, "s_min");
    chk("s_min_ref", ref_mul(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 64),
        128'h4000_0000_0000_0000_0000_0000_0000_0000);
    main_op('1, '1, 1'b0, 0, "u_ones");
    chk("u_ones_ref", ref_mul('1, '1, 1'b0, 64),
        128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    main_op(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 1'b1, 10, "bp");

    // Abort mid-BUSY: the pending product must never appear.
    a = 64'd1234; b = 64'd5678; is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    q.push_back(ref_mul(64'd1234, 64'd5678, 1'b0, 64));
    #1 in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    void'(q.pop_back());
    chk("abort_in_ready", 128'(in_ready), 128'd1);
    chk("abort_out_valid", 128'(out_valid), 128'd0);
    seen = 1'b0;
    repeat (30) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("abort_no_out", 128'(seen), 128'd0);
    main_op(64'd77, 64'd99, 1'b0, 0, "post_abort");

    for (int n = 0; n < 40; n++) begin
      main_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
              $urandom_range(0, 2), "rnd64_4");
    end

    guard = 0;
    while (gen_done < NUM_GEN && guard < 20000) begin
      @(posedge clk);
      guard++;
    end
    chk("gen_all_done", 128'(gen_done), 128'(NUM_GEN));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Random regression across other WIDTH/DIGIT shapes, each on its own instance.
  for (genvar g = 0; g < NUM_GEN; g++) begin : g_cfg
    localparam int W = (g < 3) ? 8 : 64;
    localparam int D = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 8 : (g == 3) ? 1 : 64;

    logic           g_rst, g_in_valid, g_in_ready, g_s, g_out_valid, g_out_ready;
    logic [W-1:0]   g_a, g_b;
    logic [2*W-1:0] g_mul;
    logic [127:0]   gq[$];

    seq_mul #(.WIDTH(W), .DIGIT(D)) u_gen (
      .clk(clk), .rst(g_rst), .in_valid(g_in_valid), .in_ready(g_in_ready),
      .a(g_a), .b(g_b), .is_signed(g_s), .out_valid(g_out_valid),
      .out_ready(g_out_ready), .mul(g_mul)
    );

    initial begin
      logic [63:0] ra, rb;
      int k;
      g_rst = 1'b1; g_in_valid = 1'b0; g_out_ready = 1'b1;
      g_a = '0; g_b = '0; g_s = 1'b0;
      repeat (2) @(posedge clk);
      #1 g_rst = 1'b0;
      for (int n = 0; n < 20; n++) begin
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        if (n == 0) begin ra = 64'd1 << (W - 1); rb = ra; end
        g_a = ra[W-1:0]; g_b = rb[W-1:0]; g_s = (n == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        g_in_valid = 1'b1;
        chk("gen_in_ready", 128'(g_in_ready), 128'd1);
        @(posedge clk);
        gq.push_back(ref_mul(64'(g_a), 64'(g_b), g_s, W));
        #1 g_in_valid = 1'b0;
        k = 0;
        while (!g_out_valid && k < 200) begin
          @(posedge clk); #1;
          k++;
        end
        chk("gen_lat", 128'(k), 128'(W / D));
        chk("gen_mul", 128'(g_mul), gq.pop_front());
        @(posedge clk); #1;
      end
      gen_done++;
    end
  end

endmodule
